instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter, issues word requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small FIFO. It presents `instr`/`instr_pc` to decode (whose main decoder consumes `instr[6:0]` and `instr[14:12]`) and handles redirects from branch/jump resolution by flushing and discarding stale responses.

---
 rtl/instr_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, in-order response FIFO,
// redirect flush. Optional opcode pre-check enabled by defining FETCH_ILLEGAL_CHECK_EN.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_illegal
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DepthExt = DEPTH[CW:0];
    localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   word_d [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];

    logic          acc;
    logic          pop;
    logic          rsp_take;
    logic          push;
    logic [CW:0]   credit_used;

`ifdef FETCH_ILLEGAL_CHECK_EN
    logic          ill_q [DEPTH];
    logic          ill_d [DEPTH];

    // Flags exactly the encodings the downstream decoder has no behaviour for.
    function automatic logic opcode_illegal(input logic [31:0] w);
        logic ill;
        case (w[6:0])
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: ill = 1'b0;
            7'b1100011: ill = (w[14:12] == 3'b010) || (w[14:12] == 3'b011);
            default:    ill = 1'b1;
        endcase
        return ill;
    endfunction
`endif

    // Handshake and output decode.
    always_comb begin
        instr_valid    = (count_q != '0);
        pop            = instr_valid && instr_ready;
        credit_used    = {1'b0, count_q} + {1'b0, outstanding_q} - {{CW{1'b0}}, pop};
        imem_req_valid = !redirect_valid && (credit_used < DepthExt);
        imem_addr      = pc_q;
        acc            = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && (outstanding_q != '0);
        push           = rsp_take && (drop_q == '0) && !redirect_valid;
        instr          = word_q[rd_ptr_q];
        instr_pc       = addr_q[rd_ptr_q];
`ifdef FETCH_ILLEGAL_CHECK_EN
        instr_illegal  = instr_valid && ill_q[rd_ptr_q];
`else
        instr_illegal  = 1'b0;
`endif
    end

    // Next-state for pointers, counters and FIFO storage.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(acc) - CW'(rsp_take);
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        word_d        = word_q;
        addr_d        = addr_q;
`ifdef FETCH_ILLEGAL_CHECK_EN
        ill_d         = ill_q;
`endif

        if (acc) begin
            pc_d = pc_q + 32'd4;
        end
        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if (push) begin
            word_d[wr_ptr_q] = imem_rsp_data;
            addr_d[wr_ptr_q] = rsp_pc_q;
`ifdef FETCH_ILLEGAL_CHECK_EN
            ill_d[wr_ptr_q]  = opcode_illegal(imem_rsp_data);
`endif
            wr_ptr_d = wr_ptr_q + 1'b1;
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // Flush: everything still in flight becomes stale and must be discarded on arrival.
        if (redirect_valid) begin
            pc_d     = redirect_pc & AlignMask;
            rsp_pc_d = redirect_pc & AlignMask;
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            drop_d   = outstanding_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC & AlignMask;
            rsp_pc_q      <= RESET_PC & AlignMask;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
`ifdef FETCH_ILLEGAL_CHECK_EN
                ill_q[i]  <= 1'b0;
`endif
            end
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            word_q        <= word_d;
            addr_q        <= addr_d;
`ifdef FETCH_ILLEGAL_CHECK_EN
            ill_q         <= ill_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: in-order memory model with random latency and a
// reference model of the decode-visible PC stream (sequential, restarting at each redirect).
module tb_instr_fetch_unit;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_illegal;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_illegal  (instr_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t        mq[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_pops = 0;
    int unsigned n_acc = 0;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;
    int unsigned rsp_pct = 100, rdy_pct = 100, req_rdy_pct = 100, redir_pct = 0, lat_extra = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = '0;
    logic        acc_s = 1'b0;
    logic        pop_s = 1'b0;
    logic        after_redir = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Memory contents: opcode mix indexed by address, upper bits tagged with the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] base;
        case (a[5:2])
            4'd0:    base = 32'h0000_007F;
            4'd1:    base = 32'h0000_0033;
            4'd2:    base = 32'h0000_2063;
            4'd3:    base = 32'h0000_0063;
            4'd4:    base = 32'h0000_0003;
            4'd5:    base = 32'h0000_0023;
            4'd6:    base = 32'h0000_0013;
            4'd7:    base = 32'h0000_006F;
            4'd8:    base = 32'h0000_0067;
            4'd9:    base = 32'h0000_0037;
            4'd10:   base = 32'h0000_0017;
            4'd11:   base = 32'h0000_000B;
            4'd12:   base = 32'h0000_3063;
            4'd13:   base = 32'h0000_1063;
            4'd14:   base = 32'h0000_0057;
            default: base = 32'h0000_0073;
        endcase
        return base | {a[23:7], 15'h0};
    endfunction

    function automatic logic ref_illegal(input logic [31:0] w);
`ifdef FETCH_ILLEGAL_CHECK_EN
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        if (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 || op == 7'h6F ||
            op == 7'h67 || op == 7'h37 || op == 7'h17) return 1'b0;
        if (op == 7'h63) return (f3 == 3'd2) || (f3 == 3'd3);
        return 1'b1;
`else
        return (w == 32'hDEAD_BEEF) && 1'b0;
`endif
    endfunction

    // One clock cycle: drive at negedge, sample 1 ns later, update models for the next posedge.
    task automatic step();
        logic rsp_fire;
        req_t r;
        @(negedge clk);
        rsp_fire = (mq.size() != 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_valid = rsp_fire;
        imem_rsp_data  = rsp_fire ? word_of(mq[0].addr) : $urandom();
        imem_req_ready = $urandom_range(99) < req_rdy_pct;
        instr_ready    = $urandom_range(99) < rdy_pct;
        redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
        redirect_pc    = force_redir ? force_pc : $urandom();
        force_redir    = 1'b0;
        #1;
        acc_s = imem_req_valid && imem_req_ready;
        pop_s = instr_valid && instr_ready;
        if (after_redir) check_eq("valid_after_redir", 32'(instr_valid), 32'd0);
        if (redirect_valid) check_eq("req_in_redir", 32'(imem_req_valid), 32'd0);
        if (acc_s) begin
            check_eq("req_addr", imem_addr, exp_req);
            r.addr = imem_addr;
            r.due  = cyc + 1 + $urandom_range(lat_extra);
            mq.push_back(r);
            check_eq("inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
            exp_req = exp_req + 32'd4;
            n_acc++;
        end
        if (pop_s) begin
            check_eq("pop_pc", instr_pc, exp_pc);
            check_eq("pop_word", instr, word_of(exp_pc));
            check_eq("pop_illegal", 32'(instr_illegal), 32'(ref_illegal(word_of(exp_pc))));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (redirect_valid) begin
            exp_req = redirect_pc & 32'hFFFF_FFFC;
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
        end
        after_redir = redirect_valid;
        if (rsp_fire) r = mq.pop_front();
        cyc++;
    endtask

    // Called right after step(): asserts reset before the next posedge.
    task automatic do_reset();
        #1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", instr_pc, 32'd0);
        check_eq("rst_illegal", 32'(instr_illegal), 32'd0);
        mq.delete();
        exp_req     = RESET_PC;
        exp_pc      = RESET_PC;
        after_redir = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned base;
        do_reset();

        // Single-cycle memory, decode always ready: back-to-back requests and pops.
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq("tp_req", 32'(acc_s), 32'd1);
            check_eq("tp_pop", 32'(pop_s), 32'(i >= 2));
        end

        // Stall decode until the FIFO fills, then reset mid-stream.
        rdy_pct = 0;
        for (int i = 0; i < 6; i++) step();
        check_eq("full_valid", 32'(instr_valid), 32'd1);
        do_reset();

        // Stall from empty: only DEPTH requests may be accepted.
        base = n_acc;
        for (int i = 0; i < 8; i++) step();
        check_eq("stall_acc", n_acc - base, DEPTH);
        rdy_pct = 100;
        base = n_pops;
        for (int i = 0; i < 8; i++) step();
        check_eq("release_pops", n_pops - base, 32'd8);

        // Redirect with two outstanding and a response landing in the redirect cycle.
        do_reset();
        rsp_pct = 0;
        step();
        step();
        rsp_pct     = 100;
        force_redir = 1'b1;
        force_pc    = 32'h0000_0100;
        step();
        step();
        check_eq("redir_req_n1", 32'(acc_s), 32'd1);
        step();
        check_eq("redir_valid_n2", 32'(instr_valid), 32'd0);
        step();
        check_eq("redir_pop_n3", 32'(pop_s), 32'd1);
        for (int i = 0; i < 4; i++) step();

        // Redirect near the top of the address space; low bits of the target are ignored.
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFFF;
        step();
        base = n_pops;
        for (int i = 0; i < 8; i++) step();
        check_eq("wrap_pops", 32'(n_pops - base >= 3), 32'd1);

        // Random traffic: backpressure, variable latency, random redirects.
        rsp_pct = 70; rdy_pct = 70; req_rdy_pct = 70; redir_pct = 3; lat_extra = 3;
        for (int i = 0; i < 4000; i++) step();

        // Drain with a bounded budget; stalling forever is a failure.
        rsp_pct = 100; rdy_pct = 100; req_rdy_pct = 100; redir_pct = 0;
        base = n_pops;
        for (int i = 0; i < 100 && (n_pops - base) < 20; i++) step();
        check_eq("drain_progress", 32'(n_pops - base >= 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
